// File: rtl/avg_decim_pkg.sv
// Shared types and sizing helpers for the averaging decimator.
package avg_decim_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int DEF_BITWIDTH = 32;
    localparam int DEF_MAX_LOG2 = 4;

    // Summing up to 2^max_log2 samples adds max_log2 bits of headroom.
    function automatic int acc_width(input int bitwidth, input int max_log2);
        return bitwidth + max_log2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers, occupancy counter and drop indication.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_RST,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign w_do_pop  = i_pop && (r_level != '0);
    assign w_do_push = i_push && ((r_level != LW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_level != '0);
    assign o_level = r_level;
    assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/avg_decim.sv
// Averaging decimator: sums 2^k input samples, emits sum >> k into an output FIFO.
module avg_decim
    import avg_decim_pkg::*;
#(
    parameter int BITWIDTH   = DEF_BITWIDTH,
    parameter int MAX_LOG2   = DEF_MAX_LOG2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            n_RST,
    input  logic [BITWIDTH-1:0]             sig_in,
    input  logic                            in_valid,
    input  logic [$clog2(MAX_LOG2+1)-1:0]   decim_log2,
    input  logic                            clr_ovf,
    output logic [BITWIDTH-1:0]             out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output state_e                          o_dbg_state
);

    localparam int KW   = $clog2(MAX_LOG2+1);
    localparam int ACCW = acc_width(BITWIDTH, MAX_LOG2);
    localparam int CW   = MAX_LOG2 + 1;

    state_e           r_state;
    logic [ACCW-1:0]  r_acc;
    logic [CW-1:0]    r_cnt;
    logic [KW-1:0]    r_k_lat;
    logic             r_ovf;

    logic [KW-1:0]     w_k_clamp;
    logic [KW-1:0]     w_k_eff;
    logic [ACCW-1:0]   w_sig_ext;
    logic [ACCW-1:0]   w_acc_next;
    logic [CW-1:0]     w_cnt_next;
    logic [CW-1:0]     w_target;
    logic              w_done;
    logic [ACCW-1:0]   w_avg_full;
    logic [BITWIDTH-1:0] w_avg;
    logic              w_drop;

    assign w_k_clamp = (decim_log2 > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : decim_log2;
    assign w_sig_ext = {{MAX_LOG2{1'b0}}, sig_in};

    // Frame values as they will stand once the current valid sample is taken.
    always_comb begin
        w_k_eff    = r_k_lat;
        w_acc_next = r_acc + w_sig_ext;
        w_cnt_next = r_cnt + CW'(1);
        if (r_state == IDLE) begin
            w_k_eff    = w_k_clamp;
            w_acc_next = w_sig_ext;
            w_cnt_next = CW'(1);
        end
    end

    assign w_target   = CW'(1) << w_k_eff;
    assign w_done     = in_valid && (w_cnt_next == w_target);
    assign w_avg_full = w_acc_next >> w_k_eff;
    assign w_avg      = w_avg_full[BITWIDTH-1:0];

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_k_lat <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (r_state == IDLE) begin
                    r_k_lat <= w_k_clamp;
                end
                r_state <= w_done ? IDLE : ACCUM;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Output handshake: a word transfers on any rising edge where out_valid && out_ready;
    // out_data holds while out_valid is high and out_ready is low.
    sync_fifo #(
        .WIDTH (BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .n_RST       (n_RST),
        .i_push      (w_done),
        .i_push_data (w_avg),
        .i_pop       (out_valid && out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_level     (level),
        .o_drop      (w_drop)
    );

    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule
